// File: rtl/spi_pixel_loader_if.sv
// SPI host lines and frame-buffer write port of spi_pixel_loader.
// The host/bench side takes the master modport and the loader takes the slave modport.
interface spi_pixel_loader_if #(
  parameter int unsigned N = 10,
  parameter int unsigned M = 3
);
  logic         sck;
  logic         sdi;
  logic         load;
  logic         we;
  logic [N-1:0] adr_out;
  logic [M-1:0] rgb_out;
  logic         frame_done;
  logic         frame_err;

  modport master (
    output sck,
    output sdi,
    output load,
    input  we,
    input  adr_out,
    input  rgb_out,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  sck,
    input  sdi,
    input  load,
    output we,
    output adr_out,
    output rgb_out,
    output frame_done,
    output frame_err
  );
endinterface

// File: rtl/spi_pixel_loader.sv
// SPI slave that unpacks two 3-bit pixels per received byte into frame-buffer writes,
// auto-incrementing the pixel address and reporting frame completion and errors.
module spi_pixel_loader #(
  parameter int unsigned N = 10,
  parameter int unsigned M = 3
) (
  input  logic               clk,
  input  logic               reset,
  spi_pixel_loader_if.slave  bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRecv    = 3'd1;
  localparam logic [2:0] StWriteHi = 3'd2;
  localparam logic [2:0] StWriteLo = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [N:0] FrameLen = {1'b1, {N{1'b0}}};
  localparam logic [N:0] CntStep  = (N+1)'(2);

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic sdi_s1_q, sdi_s2_q;
  logic load_s1_q, load_s2_q, load_s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      sdi_s1_q  <= 1'b0;
      sdi_s2_q  <= 1'b0;
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
      load_s3_q <= 1'b0;
    end else begin
      sck_s1_q  <= bus.sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      sdi_s1_q  <= bus.sdi;
      sdi_s2_q  <= sdi_s1_q;
      load_s1_q <= bus.load;
      load_s2_q <= load_s1_q;
      load_s3_q <= load_s2_q;
    end
  end

  logic [2:0]   state_q, state_d;
  logic [N:0]   cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  // Only byte bits [5:0] need to be kept; bit 6 is consumed straight off the shift path.
  logic [5:0]   sr_q, sr_d;
  logic         ovf_q, ovf_d;
  logic         fall_pend_q, fall_pend_d;
  logic         rise_pend_q, rise_pend_d;
  logic         arm_q, arm_d;
  logic [1:0]   warm_q, warm_d;
  logic         we_q, we_d;
  logic [N-1:0] adr_q, adr_d;
  logic [M-1:0] rgb_q, rgb_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         sck_rise, load_rise, load_fall, partial;
  logic [6:0]   byte_nx;

  assign sck_rise  = sck_s2_q & ~sck_s3_q;
  assign load_rise = load_s2_q & ~load_s3_q & arm_q;
  assign load_fall = ~load_s2_q & load_s3_q;
  assign byte_nx   = {sr_q, sdi_s2_q};
  assign partial   = (bit_q != 3'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    ovf_d       = ovf_q;
    fall_pend_d = fall_pend_q;
    rise_pend_d = rise_pend_q;
    arm_d       = arm_q;
    warm_d      = warm_q[1] ? warm_q : warm_q + 2'd1;
    we_d        = 1'b0;
    adr_d       = adr_q;
    rgb_d       = rgb_q;
    done_d      = 1'b0;
    err_d       = err_q;

    // A load already high when reset releases must not look like a fresh frame start:
    // a rise is only accepted once load has been seen low after the synchronizer filled.
    if (warm_q[1] && !load_s2_q) begin
      arm_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (load_rise || rise_pend_q) begin
          cnt_d       = '0;
          bit_d       = '0;
          sr_d        = '0;
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          fall_pend_d = 1'b0;
          rise_pend_d = 1'b0;
          state_d     = StRecv;
        end
      end
      StRecv: begin
        if (load_fall || fall_pend_q) begin
          fall_pend_d = 1'b0;
          done_d      = 1'b1;
          err_d       = (cnt_q != FrameLen) | ovf_q | partial;
          state_d     = StDone;
        end else if (sck_rise && load_s2_q) begin
          sr_d  = byte_nx[5:0];
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (cnt_q < FrameLen) begin
              we_d    = 1'b1;
              adr_d   = cnt_q[N-1:0];
              rgb_d   = M'(byte_nx[6:4]);
              state_d = StWriteHi;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      StWriteHi: begin
        we_d    = 1'b1;
        adr_d   = cnt_q[N-1:0] + N'(1);
        rgb_d   = M'(sr_q[2:0]);
        state_d = StWriteLo;
        if (load_fall) begin
          fall_pend_d = 1'b1;
        end
      end
      StWriteLo: begin
        cnt_d   = cnt_q + CntStep;
        state_d = StRecv;
        if (load_fall) begin
          fall_pend_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (load_rise) begin
          rise_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      ovf_q       <= 1'b0;
      fall_pend_q <= 1'b0;
      rise_pend_q <= 1'b0;
      arm_q       <= 1'b0;
      warm_q      <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      rgb_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      ovf_q       <= ovf_d;
      fall_pend_q <= fall_pend_d;
      rise_pend_q <= rise_pend_d;
      arm_q       <= arm_d;
      warm_q      <= warm_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      rgb_q       <= rgb_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.we         = we_q;
  assign bus.adr_out    = adr_q;
  assign bus.rgb_out    = rgb_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Scoreboard bench for spi_pixel_loader: the driver pushes expected writes, write timing
// and frame results from a byte-level model; a negedge monitor pops and compares.
module tb_spi_pixel_loader;
  localparam int unsigned N = 10;
  localparam int unsigned M = 3;
  localparam int HalfFrame = 1 << (N - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_pixel_loader_if #(.N(N), .M(M)) bus ();

  spi_pixel_loader #(.N(N), .M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] adr;
    logic [M-1:0] rgb;
  } wr_t;

  typedef struct packed {
    logic err;
    int   fall;
  } fr_t;

  wr_t wq[$];
  fr_t fq[$];
  int  lq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int we_run = 0;
  int done_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Byte idx of the frame; accepted bytes land at pixel 2*idx and 2*idx+1.
  task automatic send_byte(input logic [7:0] b, input bit accept, input int idx, input bit drop);
    for (int i = 7; i >= 0; i--) begin
      bus.sdi = b[i];
      tick(3);
      bus.sck = 1'b1;
      if (i == 0 && accept) begin
        wq.push_back('{adr: N'(2 * idx), rgb: M'(b[6:4])});
        wq.push_back('{adr: N'(2 * idx + 1), rgb: M'(b[2:0])});
        lq.push_back(cyc + 3);
      end
      if (i == 0 && drop) begin
        tick(2);
        bus.load = 1'b0;
        fall_cyc = cyc;
        tick(1);
      end else begin
        tick(3);
      end
      bus.sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbytes, input int pbits, input bit fixed,
                           input logic [7:0] fv, input bit drop);
    logic [7:0] b;
    bus.load = 1'b1;
    tick(6);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_at_rise got %0b want 0", bus.frame_err);
    end
    for (int i = 0; i < nbytes; i++) begin
      b = fixed ? fv : 8'($urandom);
      send_byte(b, i < HalfFrame, i, drop && (i == nbytes - 1));
    end
    for (int i = 0; i < pbits; i++) begin
      bus.sdi = 1'($urandom);
      tick(3);
      bus.sck = 1'b1;
      tick(3);
      bus.sck = 1'b0;
    end
    if (!drop) begin
      tick(6);
      bus.load = 1'b0;
      fall_cyc = cyc;
    end
    fq.push_back('{err: (nbytes != HalfFrame) || (pbits != 0), fall: fall_cyc});
    tick(10);
  endtask

  always @(negedge clk) begin
    wr_t got;
    wr_t w;
    fr_t f;
    int  e;
    if (reset) begin
      we_run   = 0;
      done_run = 0;
    end else begin
      if (bus.we) begin
        if (we_run == 0) begin
          checks++;
          if (lq.size() == 0) begin
            errors++;
            $display("FAIL write_latency got we at cycle %0d want no write", cyc);
          end else begin
            e = lq.pop_front();
            if (cyc != e) begin
              errors++;
              $display("FAIL write_latency got cycle %0d want %0d", cyc, e);
            end
          end
        end
        we_run++;
        got.adr = bus.adr_out;
        got.rgb = bus.rgb_out;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got adr %0d rgb %0d want none", got.adr, got.rgb);
        end else begin
          w = wq.pop_front();
          if (got !== w) begin
            errors++;
            $display("FAIL write got adr %0d rgb %0d want adr %0d rgb %0d",
                     got.adr, got.rgb, w.adr, w.rgb);
          end
        end
      end else if (we_run != 0) begin
        checks++;
        if (we_run != 2) begin
          errors++;
          $display("FAIL we_run got %0d cycles want 2", we_run);
        end
        we_run = 0;
      end

      if (bus.frame_done) begin
        done_run++;
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got frame_done at cycle %0d want none", cyc);
        end else begin
          f = fq.pop_front();
          checks++;
          if (bus.frame_err !== f.err) begin
            errors++;
            $display("FAIL frame_err got %0b want %0b", bus.frame_err, f.err);
          end
          checks++;
          if (cyc < f.fall + 3 || cyc > f.fall + 5) begin
            errors++;
            $display("FAIL done_timing got %0d cycles after fall want 3..5", cyc - f.fall);
          end
        end
      end else if (done_run != 0) begin
        checks++;
        if (done_run != 1) begin
          errors++;
          $display("FAIL done_width got %0d cycles want 1", done_run);
        end
        done_run = 0;
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.we, bus.adr_out, bus.rgb_out, bus.frame_done, bus.frame_err} !== '0) begin
      errors++;
      $display("FAIL %s got we %b adr %0d rgb %0d done %b err %b want all 0", name, bus.we,
               bus.adr_out, bus.rgb_out, bus.frame_done, bus.frame_err);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sck  = 1'b0;
    bus.sdi  = 1'b0;
    bus.load = 1'b0;
    reset    = 1'b1;
    tick(3);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    tick(5);

    run_frame(HalfFrame, 0, 1'b1, 8'h71, 1'b0);      // full frame of 0x71
    run_frame(1, 0, 1'b1, 8'h35, 1'b0);              // single byte, short frame
    run_frame(HalfFrame + 2, 0, 1'b0, 8'h00, 1'b0);  // overflow
    run_frame(100, 5, 1'b0, 8'h00, 1'b0);            // trailing partial byte
    run_frame(4, 0, 1'b0, 8'h00, 1'b0);              // next frame restarts at adr 0
    run_frame(1, 0, 1'b0, 8'h00, 1'b1);              // load drops during write

    // Reset mid-frame: outputs clear at once and load held high is not a new frame.
    bus.load = 1'b1;
    tick(6);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom), 1'b1, i, 1'b0);
    end
    tick(6);
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_frame");
    wq.delete();
    lq.delete();
    tick(2);
    reset = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'b0, 0, 1'b0);
    end
    tick(6);
    bus.load = 1'b0;
    tick(10);
    check_outputs_zero("after_reset_no_activity");

    run_frame(6, 0, 1'b0, 8'h00, 1'b0);              // recovery after reset
    tick(20);

    checks++;
    if (wq.size() != 0 || lq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d writes %0d frames pending want 0 0", wq.size(), fq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
